mul_66x68_sched: RTL and testbench
==================================

MUL_66X68_SCHED -- requirements
Module: mul_66x68_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter MUL_LAT, default 8, fixed latency in cycles of the attached non-stallable 66x68 multiplier (1..16).
REQ-003 SHALL have parameter RSP_DEPTH, default 16, response buffer entries (power of two, at least MUL_LAT).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester request valid.
REQ-007 SHALL have port req_ready  output  N_REQ  per-requester grant; at most one bit high per cycle.
REQ-008 SHALL have port req_a  input  N_REQ*66  operand A, requester i in bits [66i+65:66i].
REQ-009 SHALL have port req_b  input  N_REQ*68  operand B, requester i in bits [68i+67:68i].
REQ-010 SHALL have port mul_a  output  66  operand A to multiplier.
REQ-011 SHALL have port mul_b  output  68  operand B to multiplier.
REQ-012 SHALL have port mul_c  input  134  product from multiplier, valid MUL_LAT cycles after operands were presented.
REQ-013 SHALL have port rsp_valid  output  1  response available.
REQ-014 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-015 SHALL have port rsp_id  output  clog2(N_REQ)  originating requester index.
REQ-016 SHALL have port rsp_c  output  134  product A*B.

Function
REQ-017 A request from requester i SHALL transfer in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-018 Grant SHALL be round-robin: search starts at index (last granted + 1) mod N_REQ; after reset the search starts at 0.
REQ-019 req_ready SHALL be combinationally derived from req_valid, round-robin pointer and credit; no grant SHALL be given to a requester with req_valid low.
REQ-020 An issue SHALL be permitted only when in_flight + fifo_count < RSP_DEPTH, guaranteeing no response-buffer overflow because the multiplier cannot stall.
REQ-021 On issue, mul_a/mul_b SHALL carry the granted operands in the same cycle; otherwise they SHALL be driven to zero.
REQ-022 A valid/id shift pipeline of depth MUL_LAT SHALL track each issue; when its tail is valid, mul_c and the id SHALL be written into the response buffer in that cycle.
REQ-023 in_flight SHALL increment on issue, decrement on pipeline-tail write, and stay unchanged when both occur in one cycle.
REQ-024 The response buffer SHALL be a FIFO preserving issue order; rsp_valid SHALL be high iff the FIFO is not empty; a pop occurs on rsp_valid and rsp_ready.
REQ-025 Simultaneous push and pop SHALL be legal when full or empty (empty: push only; full: pop frees the entry, push refused upstream by REQ-020).
REQ-026 FIFO pointers SHALL wrap modulo RSP_DEPTH.
REQ-027 rsp_c/rsp_id SHALL hold stable while rsp_valid is high and rsp_ready is low.
REQ-028 Sustained throughput SHALL be one issue per cycle when rsp_ready stays high.
REQ-029 Minimum request-to-response latency SHALL be MUL_LAT+1 cycles (FIFO registered output).

Reset
REQ-030 While rst is low at a clock edge: req_ready=0, rsp_valid=0, rsp_id=0, rsp_c=0, mul_a=0, mul_b=0, in_flight=0, FIFO empty, round-robin pointer=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight and buffered results; products emerging from the multiplier after reset release SHALL be ignored (pipeline valid bits cleared).

Structure
REQ-032 N_REQ limits, operand/product widths (66, 68, 134) and the request/response record typedefs SHALL live in a shared package mul_sched_pkg.
REQ-033 The response FIFO SHALL be a separate sub-module mul_rsp_fifo (parameterised depth, width 134+clog2(N_REQ)).
REQ-034 The multiplier SHALL be instantiated outside this block; only the mul_* ports connect to it.

Verification
REQ-035 Single request: req 2, A=3, B=5, rsp_ready=1 -> rsp_valid exactly MUL_LAT+1 cycles later, rsp_id=2, rsp_c=15.
REQ-036 All 4 requesters valid continuously -> grants 0,1,2,3,0,... one per cycle; responses in same id order with correct products for A=2^66-1, B=2^68-1.
REQ-037 rsp_ready=0, continuous requests -> exactly RSP_DEPTH issues, then req_ready=0; raising rsp_ready drains all 16 in order, none lost or duplicated.
REQ-038 FIFO full with rsp_ready toggling every cycle -> no overflow, issues resume one per freed entry, pointer wrap-around correct.
REQ-039 Reset pulsed low 3 cycles after 3 issues -> no rsp_valid afterwards until new requests; first post-reset grant goes to requester 0.
REQ-040 Random valid/ready stimulus vs. scoreboard model -> every rsp_c equals A*B of its request, per-id order preserved, at most one req_ready high.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared widths, limits and record types for the 66x68 multiplier scheduler.
package mul_sched_pkg;

  localparam int A_W       = 66;
  localparam int B_W       = 68;
  localparam int C_W       = A_W + B_W;
  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 8;
  localparam int ID_MAX_W  = $clog2(N_REQ_MAX);

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
  } mul_req_t;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [C_W-1:0]      c;
  } mul_rsp_t;

  // Wraps an index that is at most one period past n back into 0..n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/mul_rsp_fifo.sv
// Response FIFO: registered storage, head presented directly, zero when empty.
module mul_rsp_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 136,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q < CW'(DEPTH)) || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign valid_o = (cnt_q != '0);
  assign dout_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/mul_66x68_sched.sv
// Round-robin scheduler sharing one fixed-latency, non-stallable 66x68 multiplier
// among N_REQ requesters, with credit-protected in-order response buffering.
module mul_66x68_sched
  import mul_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MUL_LAT   = 8,
  parameter int RSP_DEPTH = 16,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic [A_W-1:0]       mul_a,
  output logic [B_W-1:0]       mul_b,
  input  logic [C_W-1:0]       mul_c,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [C_W-1:0]       rsp_c
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  mul_req_t             op_arr [N_REQ];
  mul_req_t             gnt_op;
  logic [ID_W-1:0]      ptr_q, ptr_d, gnt_idx, idx_v;
  logic [CNT_W-1:0]     inflight_q, inflight_d, fifo_cnt;
  logic [MUL_LAT-1:0]   vld_q, vld_d;
  logic [ID_W-1:0]      id_q [MUL_LAT];
  logic                 found, credit_ok, issue, tail;
  logic [C_W+ID_W-1:0]  fifo_dout;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign op_arr[i].a = req_a[i*A_W +: A_W];
    assign op_arr[i].b = req_b[i*B_W +: B_W];
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx_v   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_v = ID_W'(rr_wrap(int'(ptr_q) + k, N_REQ));
      if (!found && req_valid[idx_v]) begin
        found   = 1'b1;
        gnt_idx = idx_v;
      end
    end
  end

  // Credit counts everything not yet popped, so the non-stallable pipe can always land.
  always_comb begin
    credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(RSP_DEPTH);
    issue     = rst && found && credit_ok;
    req_ready = issue ? (N_REQ'(1) << gnt_idx) : '0;
    gnt_op    = op_arr[gnt_idx];
    mul_a     = issue ? gnt_op.a : '0;
    mul_b     = issue ? gnt_op.b : '0;
  end

  assign tail  = vld_q[MUL_LAT-1];
  assign vld_d = (vld_q << 1) | MUL_LAT'(issue);

  always_comb begin
    ptr_d      = issue ? ID_W'(rr_wrap(int'(gnt_idx) + 1, N_REQ)) : ptr_q;
    inflight_d = inflight_q;
    case ({issue, tail})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      vld_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      vld_q      <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    id_q[0] <= gnt_idx;
    for (int i = 1; i < MUL_LAT; i++) id_q[i] <= id_q[i-1];
  end

  mul_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (C_W + ID_W)
  ) u_rsp_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (tail),
    .din_i   ({id_q[MUL_LAT-1], mul_c}),
    .pop_i   (rsp_ready),
    .dout_o  (fifo_dout),
    .valid_o (rsp_valid),
    .count_o (fifo_cnt)
  );

  assign rsp_id = fifo_dout[C_W +: ID_W];
  assign rsp_c  = fifo_dout[C_W-1:0];

endmodule

// File: tb/tb_mul_66x68_sched.sv
// Scoreboard bench for mul_66x68_sched with an ideal fixed-latency multiplier model.
module tb_mul_66x68_sched;

  localparam int N   = 4;
  localparam int L   = 8;
  localparam int D   = 16;
  localparam int IDW = $clog2(N);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*66-1:0]  req_a = '0;
  logic [N*68-1:0]  req_b = '0;
  logic [65:0]      mul_a;
  logic [67:0]      mul_b;
  logic [133:0]     mul_c;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [IDW-1:0]   rsp_id;
  logic [133:0]     rsp_c;

  always #5 clk = ~clk;

  mul_66x68_sched #(.N_REQ(N), .MUL_LAT(L), .RSP_DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_c     (rsp_c)
  );

  // Ideal external multiplier: product appears L cycles after operands.
  logic [133:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= 134'(mul_a) * 134'(mul_b);
    for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_c = mpipe[L-1];

  typedef struct {
    int           id;
    logic [133:0] c;
    int           cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ptr = 0;
  int          issued = 0;
  int          popped = 0;
  int          phase_issues = 0;
  bit          exact_lat = 1'b0;
  logic [65:0] a_arr [N];
  logic [67:0] b_arr [N];

  task automatic chk(input bit ok, input string name, input logic [133:0] act, input logic [133:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [65:0] r66();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[65:0];
  endfunction

  function automatic logic [67:0] r68();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[67:0];
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      a_arr[i] = r66();
      b_arr[i] = r68();
    end
  endtask

  // One clock cycle: drive, then predict grant from the round-robin/credit rules.
  task automatic step(input logic [N-1:0] v, input logic rr, input logic rst_v);
    logic [N-1:0] expr;
    int           g;
    bit           found;
    exp_t         e;
    @(negedge clk);
    cyc++;
    rst       = rst_v;
    req_valid = v;
    rsp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_a[i*66 +: 66] = a_arr[i];
      req_b[i*68 +: 68] = b_arr[i];
    end
    #1;
    if (!rst_v) begin
      sb.delete();
      ptr    = 0;
      issued = 0;
      popped = 0;
      chk(req_ready == '0, "rst_req_ready", 134'(req_ready), 134'(0));
      chk(mul_a == '0 && mul_b == '0, "rst_mul_ops", 134'(mul_a), 134'(0));
      return;
    end
    found = 1'b0;
    g     = 0;
    if (issued - popped < D) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (ptr + k) % N;
        if (!found && v[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
    end
    expr = found ? (N'(1) << g) : '0;
    chk(req_ready == expr, "req_ready", 134'(req_ready), 134'(expr));
    chk($onehot0(req_ready), "ready_onehot", 134'(req_ready), 134'(expr));
    if (found) begin
      chk(mul_a == a_arr[g] && mul_b == b_arr[g], "mul_ops", 134'(mul_a), 134'(a_arr[g]));
      e.id  = g;
      e.c   = 134'(a_arr[g]) * 134'(b_arr[g]);
      e.cyc = cyc;
      sb.push_back(e);
      ptr = (g + 1) % N;
      issued++;
      phase_issues++;
    end else begin
      chk(mul_a == '0 && mul_b == '0, "mul_idle", 134'(mul_a), 134'(0));
    end
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  initial begin : monitor
    exp_t           e;
    bit             pst = 1'b0;
    logic [IDW-1:0] pid = '0;
    logic [133:0]   pc = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        pst = 1'b0;
        continue;
      end
      if (pst)
        chk(rsp_valid && rsp_id == pid && rsp_c == pc, "rsp_hold", rsp_c, pc);
      if (sb.size() == 0)
        chk(!rsp_valid, "rsp_spurious", 134'(rsp_valid), 134'(0));
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk(int'(rsp_id) == e.id, "rsp_id", 134'(rsp_id), 134'(e.id));
        chk(rsp_c == e.c, "rsp_c", rsp_c, e.c);
        if (exact_lat)
          chk(cyc - e.cyc == L + 1, "lat_exact", 134'(cyc - e.cyc), 134'(L + 1));
        else
          chk(cyc - e.cyc >= L + 1, "lat_min", 134'(cyc - e.cyc), 134'(L + 1));
        popped++;
      end
      pst = rsp_valid && !rsp_ready;
      pid = rsp_id;
      pc  = rsp_c;
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    repeat (3) step('0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b1);
    chk(!rsp_valid && rsp_c == '0 && rsp_id == '0, "reset_state", rsp_c, 134'(0));

    // Single request from requester 2: 3*5 with exact latency.
    a_arr[2]  = 66'd3;
    b_arr[2]  = 68'd5;
    exact_lat = 1'b1;
    step(4'b0100, 1'b1, 1'b1);
    repeat (L + 4) step('0, 1'b1, 1'b1);
    exact_lat = 1'b0;

    // All requesters, maximal operands.
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '1;
      b_arr[i] = '1;
    end
    repeat (20) step('1, 1'b1, 1'b1);
    repeat (L + 4) step('0, 1'b1, 1'b1);

    // Consumer stalled: exactly D issues, then drain.
    rand_ops();
    phase_issues = 0;
    repeat (D + 10) step('1, 1'b0, 1'b1);
    chk(phase_issues == D, "stall_issues", 134'(phase_issues), 134'(D));
    repeat (D + L + 4) step('0, 1'b1, 1'b1);
    chk(sb.size() == 0, "stall_drain", 134'(sb.size()), 134'(0));

    // Full buffer with toggling consumer, exercising pointer wrap.
    repeat (D + L) begin
      rand_ops();
      step('1, 1'b0, 1'b1);
    end
    for (int t = 0; t < 80; t++) begin
      rand_ops();
      step('1, 1'(t % 2), 1'b1);
    end
    repeat (D + L + 4) step('0, 1'b1, 1'b1);

    // Reset mid-flight: pending products must be discarded.
    rand_ops();
    step(4'b0010, 1'b1, 1'b1);
    step(4'b0100, 1'b1, 1'b1);
    step(4'b1000, 1'b1, 1'b1);
    repeat (3) step('0, 1'b1, 1'b1);
    repeat (2) step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b1);
    chk(!rsp_valid && rsp_c == '0 && rsp_id == '0, "post_reset", rsp_c, 134'(0));
    repeat (L + 6) step('0, 1'b1, 1'b1);
    step('1, 1'b1, 1'b1);
    chk(req_ready == 4'b0001, "post_reset_grant", 134'(req_ready), 134'(1));
    repeat (L + 4) step('0, 1'b1, 1'b1);

    // Random traffic.
    for (int t = 0; t < 500; t++) begin
      rand_ops();
      if ($urandom_range(0, 15) == 0) begin
        a_arr[$urandom_range(0, N - 1)] = '1;
        b_arr[$urandom_range(0, N - 1)] = '1;
      end
      step(N'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
    end
    repeat (D + L + 8) step('0, 1'b1, 1'b1);
    chk(sb.size() == 0, "final_drain", 134'(sb.size()), 134'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
